gf8_pow_seq: RTL and testbench
==============================

// Module: gf8_pow_seq
// PURPOSE
//  Sequenced GF(2^8) exponentiation unit: result = base^exp over field x^8 + POLY.
//  Time-shares one combinational GF(2^8) multiplier, one multiply per cycle, using MSB-first square-and-multiply.
//  exp=8'hFE gives the multiplicative inverse (0 maps to 0).
//  Sits beside the field multiplier in the AES/field datapath as its controller.
//  Feeds S-box, key-schedule and inversion consumers over a valid/ready handshake.
// PARAMETERS
//  POLY   8'h1B   low byte of the reduction polynomial (x^8 implied); forwarded to the multiplier
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  request valid
//  in_ready   out  1  unit idle and able to accept
//  base       in   8  field element to raise
//  exp        in   8  unsigned exponent
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  result     out  8  base^exp
//  busy       out  1  high in SQR/MUL/DONE
// BEHAVIOUR
//  Reset (sync, active-high):
//   - state=IDLE; in_ready=1, out_valid=0, busy=0, result=8'h00; acc=8'h01; bit index=7.
//   - Reset mid-operation discards the job; no output is produced.
//  Accept:
//   - On in_valid && in_ready, base and exp are registered and acc is set to 8'h01.
//   - Later changes on base/exp are ignored.
//  States:
//   - IDLE: in_ready=1. Goes to SQR on accept.
//   - SQR:  acc <= acc*acc.
//           If exp[idx]=1, go to MUL. Otherwise, go to SQR with idx-1, or to DONE when idx=0.
//   - MUL:  acc <= acc*base_r. Then go to SQR with idx-1, or to DONE when idx=0.
//   - DONE: out_valid=1, result=acc held stable. On out_ready, go to IDLE.
//  Always 8 SQR cycles (leading squares of 1 are harmless), plus one MUL per set exp bit.
//  Latency: accept in cycle T -> out_valid first high in cycle T+1+8+popcount(exp).
//   - exp=8'h00 -> T+9; exp=8'hFE -> T+16; exp=8'hFF -> T+17.
//  Handshake:
//   - in_ready=0 outside IDLE; there is no accept in the same cycle as output retire.
//   - The next accept is possible one cycle after out_valid&&out_ready.
//   - out_valid, once high, stays high with result stable until out_ready.
//  Boundaries:
//   - 0^0 = 1; 0^e = 0 for e>0.
//   - x^255 = 1 for x != 0.
//   - in_valid while busy is ignored; the requester holds it.
//  Arithmetic:
//   - All operands are 8-bit; multiplication is carry-less, reduced mod x^8+POLY.
//   - No other arithmetic.
//  Multiplier operand mux: SQR -> (acc,acc); MUL -> (acc,base_r). Output is registered only into acc.
// STRUCTURE
//  Shared package:
//   - state enum {IDLE,SQR,MUL,DONE};
//   - GF8_POLY_AES=8'h1B;
//   - GF8_ONE=8'h01;
//   - GF8_EXP_INV=8'hFE.
//  One sub-module: gf8_mul (combinational shift-and-xor multiplier, parameter POLY), single instance.
//  Top holds the FSM, 3-bit bit index, base_r/exp_r/acc registers and the operand mux.
// TESTING
//  - Inverse: base=8'h53, exp=8'hFE -> result=8'hCA, out_valid at T+16.
//  - base=8'h02, exp=8'h08 -> 8'h1B at T+10.
//  - base=8'h57, exp=8'h01 -> 8'h57 at T+10.
//  - base=8'h03, exp=8'hFF -> 8'h01 at T+17.
//  - base=8'h00, exp=8'h00 -> 8'h01; base=8'h00, exp=8'hFE -> 8'h00.
//  - Hold out_ready=0 for 5 cycles: result/out_valid stable, in_ready=0, new in_valid ignored.
//    Then assert rst mid-SQR: IDLE next cycle, out_valid never rises.
//  - Random sweep of all 256 bases x random exp vs. a software model, with random out_ready stalls.

Source files
------------

// File: rtl/gf8_pow_seq_pkg.sv
// Shared types and constants for the sequenced GF(2^8) exponentiation unit.
package gf8_pow_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } gf8_state_t;

    localparam logic [7:0] GF8_POLY_AES = 8'h1B;
    localparam logic [7:0] GF8_ONE      = 8'h01;
    localparam logic [7:0] GF8_EXP_INV  = 8'hFE;

endpackage

// File: rtl/gf8_pow_seq_mul.sv
// Combinational GF(2^8) multiplier: carry-less shift-and-xor product reduced mod x^8 + POLY.
module gf8_mul #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] a_sh;
    logic [7:0] acc_p;

    // a_sh walks a*x^i (already reduced) while each set bit of b folds it into the product.
    always_comb begin
        a_sh  = a;
        acc_p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc_p = acc_p ^ a_sh;
            end
            a_sh = {a_sh[6:0], 1'b0} ^ (a_sh[7] ? POLY : 8'h00);
        end
        p = acc_p;
    end

endmodule

// File: rtl/gf8_pow_seq.sv
// MSB-first square-and-multiply controller time-sharing one GF(2^8) multiplier.
module gf8_pow_seq
    import gf8_pow_seq_pkg::*;
#(
    parameter logic [7:0] POLY = GF8_POLY_AES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] base,
    input  logic [7:0] exp,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       busy
);

    gf8_state_t state;
    logic [2:0] idx;
    logic [7:0] base_r;
    logic [7:0] exp_r;
    logic [7:0] acc;
    logic [7:0] op_b;
    logic [7:0] prod;

    assign op_b = (state == MUL) ? base_r : acc;

    gf8_mul #(.POLY(POLY)) u_mul (
        .a (acc),
        .b (op_b),
        .p (prod)
    );

    // Every SQR/MUL step writes the product into acc; the last step of bit 0 also publishes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= 8'h00;
            acc       <= GF8_ONE;
            idx       <= 3'd7;
            base_r    <= 8'h00;
            exp_r     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base_r   <= base;
                        exp_r    <= exp;
                        acc      <= GF8_ONE;
                        idx      <= 3'd7;
                        state    <= SQR;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SQR: begin
                    acc <= prod;
                    if (exp_r[idx]) begin
                        state <= MUL;
                    end else if (idx == 3'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= prod;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                MUL: begin
                    acc <= prod;
                    if (idx == 3'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= prod;
                    end else begin
                        idx   <= idx - 3'd1;
                        state <= SQR;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf8_pow_seq.sv
// Directed-vector and sweep bench for gf8_pow_seq, using an independent repeated-multiply model.
module tb_gf8_pow_seq;
    import gf8_pow_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] base;
    logic [7:0] exp;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        logic [7:0] base;
        logic [7:0] exp;
        logic [7:0] expected;
        int         latency;
    } vec_t;

    vec_t vecs[8];

    gf8_pow_seq #(.POLY(GF8_POLY_AES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .exp       (exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference multiply walks b right-to-left, shifting the reduced copy of a.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        logic [7:0] bb;
        r  = 8'h00;
        aa = a;
        bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) r = r ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_pow(input logic [7:0] b, input logic [7:0] e);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < int'(e); k++) r = ref_mul(r, b);
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual != expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents one request, then returns the cycle (relative to accept) at which out_valid rose.
    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] e, output int lat);
        int n;
        @(negedge clk);
        checkOutput("in_ready_before_accept", int'(in_ready), 1);
        in_valid = 1'b1;
        base     = b;
        exp      = e;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        base     = ~b;
        exp      = ~e;
        checkOutput("in_ready_after_accept", int'(in_ready), 0);
        checkOutput("busy_after_accept", int'(busy), 1);
        n = 1;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        lat = n;
    endtask

    task automatic retireResult(input logic [7:0] expected, input int stalls);
        for (int s = 0; s < stalls; s++) begin
            @(negedge clk);
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_result", int'(result), int'(expected));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("retire_out_valid", int'(out_valid), 0);
        checkOutput("retire_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        logic [7:0] e;
        logic [7:0] want;

        vecs[0] = '{8'h53, GF8_EXP_INV, 8'hCA, 16};
        vecs[1] = '{8'h02, 8'h08, 8'h1B, 10};
        vecs[2] = '{8'h57, 8'h01, 8'h57, 10};
        vecs[3] = '{8'h03, 8'hFF, 8'h01, 17};
        vecs[4] = '{8'h00, 8'h00, 8'h01, 9};
        vecs[5] = '{8'h00, GF8_EXP_INV, 8'h00, 16};
        vecs[6] = '{8'h02, 8'h07, 8'h80, 12};
        vecs[7] = '{8'h02, 8'h09, 8'h36, 11};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        base      = 8'h00;
        exp       = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_result", int'(result), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].base, vecs[i].exp, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].latency);
            checkOutput($sformatf("vec%0d_result", i), int'(result), int'(vecs[i].expected));
            retireResult(vecs[i].expected, 0);
        end

        // Held result with a competing request that must be ignored.
        applyStimulus(8'h57, 8'h01, lat);
        checkOutput("hold_latency", lat, 10);
        in_valid = 1'b1;
        base     = 8'h02;
        exp      = 8'h02;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", int'(out_valid), 1);
            checkOutput("hold_result", int'(result), 8'h57);
            checkOutput("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        retireResult(8'h57, 0);

        // Reset in the middle of a squaring run drops the job.
        @(negedge clk);
        in_valid = 1'b1;
        base     = 8'h53;
        exp      = 8'hFE;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", int'(in_ready), 1);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        lat = 0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (out_valid) lat = 1;
        end
        checkOutput("midrst_no_output", lat, 0);

        // Every base with a random exponent and a random consumer stall.
        for (int b = 0; b < 256; b++) begin
            e    = 8'($urandom_range(0, 255));
            want = ref_pow(8'(b), e);
            applyStimulus(8'(b), e, lat);
            checkOutput($sformatf("sweep_b%0h_e%0h_latency", b, e), lat, 9 + $countones(e));
            checkOutput($sformatf("sweep_b%0h_e%0h_result", b, e), int'(result), int'(want));
            retireResult(want, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
